// File: rtl/adder_8b_result_stage.sv
// Result stage behind an 8-bit adder: a 2-entry in-order buffer that tags each result
// with zero/negative/overflow flags at capture and counts delivered carry-outs.
//
// state | meaning
// EMPTY | no entry held, head outputs invalid
// ONE   | head register holds the only entry
// TWO   | head plus one queued entry in the slot; upstream is stalled
module adder_8b_result_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [7:0]       in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] carry_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       zero;
        logic       neg;
        logic       ovf;
    } entry_t;

    state_t state, state_nxt;
    entry_t head, slot, captured;
    logic   accept, deliver;
    logic   head_load_in, head_load_slot, slot_load;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    // Flags are derived once here so the stored entry never depends on later inputs.
    always_comb begin
        captured.sum  = in_sum;
        captured.cout = in_cout;
        captured.zero = (in_sum == 8'h00);
        captured.neg  = in_sum[7];
        captured.ovf  = (in_a[7] == in_b[7]) && (in_sum[7] != in_a[7]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        head_load_in   = 1'b0;
        head_load_slot = 1'b0;
        slot_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    head_load_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    head_load_in = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    slot_load = 1'b1;
                end else if (deliver) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (deliver) begin
                    state_nxt      = ONE;
                    head_load_slot = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            slot <= '0;
        end else begin
            if (head_load_in) begin
                head <= captured;
            end else if (head_load_slot) begin
                head <= slot;
            end
            if (slot_load) begin
                slot <= captured;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (clr_cnt) begin
            carry_cnt <= '0;
        end else if (deliver && head.cout && (carry_cnt != {CNT_W{1'b1}})) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

    assign out_sum  = head.sum;
    assign out_cout = head.cout;
    assign out_zero = head.zero;
    assign out_neg  = head.neg;
    assign out_ovf  = head.ovf;

endmodule

// File: tb/tb_adder_8b_result_stage.sv
// Scoreboard bench for adder_8b_result_stage: random and directed traffic checked against
// a queue-based model of the 2-entry buffer and a saturating carry counter.
module tb_adder_8b_result_stage;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } stim_t;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       zero;
        logic       neg;
        logic       ovf;
    } exp_t;

    logic             clk, rst_n;
    logic             in_valid, in_ready;
    logic [7:0]       in_a, in_b, in_sum;
    logic             in_cout;
    logic             out_valid, out_ready;
    logic [7:0]       out_sum;
    logic             out_cout, out_zero, out_neg, out_ovf;
    logic             clr_cnt;
    logic [CNT_W-1:0] carry_cnt;

    adder_8b_result_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
        .clr_cnt(clr_cnt), .carry_cnt(carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    stim_t stim_q[$];
    exp_t  sb_q[$];
    int    cnt_m = 0;
    int    p_in = 0;
    int    ready_mode = 1;
    logic  acc_pend = 1'b0;
    logic  del_pend = 1'b0;
    stim_t acc_item;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input stim_t s);
        exp_t e;
        int   sa, sb, ss;
        sa = s.a[7] ? int'(s.a) - 256 : int'(s.a);
        sb = s.b[7] ? int'(s.b) - 256 : int'(s.b);
        ss = sa + sb;
        e.sum  = s.sum;
        e.cout = s.cout;
        e.zero = (s.sum == 8'd0);
        e.neg  = (s.sum >= 8'd128);
        // Overflow defined from the operands' signed values when sum is their true sum.
        if (s.sum == 8'(s.a + s.b))
            e.ovf = (ss > 127) || (ss < -128);
        else
            e.ovf = (s.a[7] == s.b[7]) && (s.sum[7] != s.a[7]);
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        logic [8:0] full;
        s.a = 8'($urandom);
        s.b = 8'($urandom);
        if ($urandom_range(3) == 0) s.b = 8'(256 - int'(s.a));
        full = {1'b0, s.a} + {1'b0, s.b};
        s.sum  = full[7:0];
        s.cout = full[8];
        return s;
    endfunction

    // Upstream driver: presents the head of stim_q, consumes it only when accepted.
    always @(negedge clk) begin
        acc_pend = 1'b0;
        if (rst_n && stim_q.size() > 0 && $urandom_range(99) < p_in) begin
            in_valid = 1'b1;
            {in_a, in_b, in_sum, in_cout} = stim_q[0];
            if (in_ready) begin
                acc_pend = 1'b1;
                acc_item = stim_q.pop_front();
            end
        end else begin
            in_valid = 1'b0;
            {in_a, in_b, in_sum, in_cout} = 25'($urandom);
        end
    end

    // Downstream consumer: chooses out_ready and notes whether a delivery will occur.
    always @(negedge clk) begin
        del_pend = 1'b0;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1));
        endcase
        if (rst_n && out_valid && out_ready) del_pend = 1'b1;
    end

    // Monitor: applies the edge's handshakes to the model, then compares.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            exp_t e;
            e = '0;
            if (del_pend) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_delivery", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                end
            end
            if (clr_cnt) cnt_m = 0;
            else if (del_pend && e.cout && cnt_m < CNT_MAX) cnt_m++;
            if (acc_pend) sb_q.push_back(model(acc_item));
            chk("out_valid", int'(out_valid), int'(sb_q.size() != 0));
            chk("in_ready", int'(in_ready), int'(sb_q.size() < 2));
            chk("carry_cnt", int'(carry_cnt), cnt_m);
            if (sb_q.size() != 0 && out_valid)
                chk("head_data", int'({out_sum, out_cout, out_zero, out_neg, out_ovf}), int'(sb_q[0]));
        end
    end

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((stim_q.size() != 0 || sb_q.size() != 0 || out_valid) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk({name, "_drain_timeout"}, int'(n >= budget), 0);
    endtask

    task automatic wait_accepted(input int budget, input string name);
        int n = 0;
        while (stim_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk({name, "_accept_timeout"}, int'(n >= budget), 0);
    endtask

    initial begin
        int t0;
        stim_t s;
        rst_n = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sum = '0; in_cout = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_data", int'({out_sum, out_cout, out_zero, out_neg, out_ovf}), 0);
        chk("rst_carry_cnt", int'(carry_cnt), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single pass with signed overflow into a negative sum.
        p_in = 100; ready_mode = 1;
        stim_q.push_back('{a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0});
        wait_drain(20, "single");
        chk("single_cnt", int'(carry_cnt), 0);

        // Carry out with zero result.
        stim_q.push_back('{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1});
        wait_drain(20, "carry_zero");
        chk("carry_zero_cnt", int'(carry_cnt), 1);

        // Backpressure: third entry must stay upstream while two are buffered.
        ready_mode = 0;
        for (int i = 0; i < 3; i++) stim_q.push_back(rand_stim());
        repeat (6) @(posedge clk);
        #2;
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_held_upstream", stim_q.size(), 1);
        ready_mode = 1;
        wait_drain(20, "backpressure");

        // Streaming: one delivery per cycle once the pipe is primed.
        for (int i = 0; i < 20; i++) stim_q.push_back(rand_stim());
        @(posedge clk);
        t0 = 0;
        while ((stim_q.size() != 0 || sb_q.size() != 0) && t0 < 100) begin
            @(posedge clk);
            t0++;
        end
        chk("stream_cycles_ok", int'(t0 <= 22), 1);
        wait_drain(20, "stream");

        // Saturation then clear colliding with a carry delivery.
        for (int i = 0; i < 17; i++) begin
            s = rand_stim();
            s.cout = 1'b1;
            stim_q.push_back(s);
        end
        wait_drain(100, "saturate");
        chk("sat_cnt", int'(carry_cnt), CNT_MAX);
        ready_mode = 0;
        s = rand_stim();
        s.cout = 1'b1;
        stim_q.push_back(s);
        wait_accepted(20, "clr");
        @(posedge clk);
        #2;
        ready_mode = 1;
        clr_cnt = 1'b1;
        @(posedge clk);
        #2;
        clr_cnt = 1'b0;
        @(posedge clk);
        #2;
        chk("clr_priority_cnt", int'(carry_cnt), 0);
        wait_drain(20, "clr");

        // Random traffic with random backpressure.
        p_in = 70; ready_mode = 2;
        for (int i = 0; i < 300; i++) stim_q.push_back(rand_stim());
        wait_drain(3000, "random");

        // Reset while two entries are buffered.
        p_in = 100; ready_mode = 0;
        stim_q.push_back(rand_stim());
        stim_q.push_back(rand_stim());
        wait_accepted(20, "midrst");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_data", int'({out_sum, out_cout, out_zero, out_neg, out_ovf}), 0);
        sb_q.delete();
        stim_q.delete();
        cnt_m = 0;
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("post_rst_out_valid", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
